host_regbank: RTL
=================

# host_regbank

Parametrised host-bus register bank for the processing core. It decodes M1 host-bus accesses and holds N_WREG configuration words, a command register and a status register. It returns readback of the configuration words, the core result words and the status register, and drives an N_DIG-digit multiplexed hex 7-segment display. It sits between the host-bus pins and the processing core.

## Interface
- N_WREG, 24: writable config words at offsets 0x00000 + 2k, for k < N_WREG.
- N_RREG, 8: read-only result words at offsets 0x00800 + 2k.
- N_DIG, 6: number of display digits.
- DIV, 25000: clk cycles per display digit slot, minimum 2.
- clk  in  1  system clock.
- nRESET  in  1  asynchronous active-low reset.
- HOST_nCS, HOST_nWE, HOST_nOE  in  1 each  host strobes, asynchronous, active-low.
- HOST_ADD  in  21  host byte address; only [19:0] is decoded.
- HDI  in  16  host write data.
- HDO  out  16  host read data, registered.
- rd_bus  in  16*N_RREG  result words; word k is [16k+15:16k].
- proc_status  in  4  core status; bit 0 = busy.
- cfg_bus  out  16*N_WREG  config words; word k is [16k+15:16k].
- proc_cmd  out  4  last command written.
- proc_start  out  1  one-cycle pulse on every command write.
- seg_value  in  4*N_DIG  display nibbles; nibble i is shown on digit i.
- SEG_COM  out  N_DIG  digit select, active-low.
- SEG_DATA  out  8  segments {a,b,c,d,e,f,g,dp}, active-high.

## Operation
- **Strobe synchronisers.** HOST_nCS, HOST_nWE and HOST_nOE each pass through a 2-flop synchroniser; the flops reset to 1.
- **Active decodes.** wr_act = !nCS & !nWE & nOE. rd_act = !nCS & !nOE. Both use synchronised strobes.
- **Write commit.** A commit happens when wr_act=1 and wr_act_d=0 (wr_act_d is wr_act delayed one cycle, reset value 1). This gives exactly one commit per host write access, regardless of strobe length. HOST_ADD and HDI are sampled on the commit cycle.
- **Odd addresses.** Any access with HOST_ADD[0]=1 is ignored.
- **Config write.** Offset 2k with k < N_WREG updates word k.
  - If proc_status[0]=1 at commit, the write is dropped and the sticky err bit is set.
- **CMD register (0x01000).** A write sets proc_cmd <= HDI[3:0] and pulses proc_start for one cycle. It is accepted even while busy.
- **STAT register (0x01002).**
  - Read value: {err, 11'b0, proc_status}.
  - A write with HDI[15]=1 clears err. Other STAT write bits have no effect.
- **Unmapped writes** are ignored.
- **Readback.** While rd_act=1, HDO is loaded every cycle from a mux:
  - config word k;
  - rd_bus word k at 0x00800 + 2k;
  - CMD, reading as {12'b0, proc_cmd};
  - STAT;
  - any other address reads 0.
  While rd_act=0, HDO holds its last value.
- **Display.**
  - A prescaler counts 0..DIV-1 and is used as an enable, not a derived clock.
  - At terminal count, the digit index advances 0..N_DIG-1 and wraps to 0.
  - Digit i drives SEG_COM bit (N_DIG-1-i) low and all other bits high.
  - SEG_DATA = {hex7(nibble i), 1'b0}, with hex7 patterns 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- **Reset values.** HDO=0, every cfg word=0, proc_cmd=0, proc_start=0, err=0, SEG_COM=all 1, SEG_DATA=0, prescaler=0, digit index=0.

## Timing
- **Write latency.** nWE falls before clk edge E0; the strobe is synchronised at edge E1; the register updates at edge E2. proc_start is high from E2 to E3.
- **Write hold.** Host data and address must be stable from E0 through E2.
- **Read latency.** nOE falls before E0; HDO is valid after E2. The host must allow at least 3 clk cycles from nOE low to sampling HDO.
- **Display timing.**
  - The first digit advance occurs DIV cycles after reset release.
  - SEG_COM and SEG_DATA change on the same edge.
  - Digit 0 is shown from reset release until that first advance.
- **Busy check.** A busy-dropped write is decided on proc_status[0] as sampled on the commit cycle.
- **Reset during an access.** Reset asserted mid-access clears all state immediately. A strobe still held low when reset is released does not commit, because wr_act_d resets to 1. The host must release and re-assert the strobe.
- **Back-to-back accesses.** Two host writes need at least 2 clk cycles with nWE high between them; otherwise they merge into one commit.

## Test plan
- **Config write and readback.** Write 0x1234 to 0x00006, then read 0x00006. Expect HDO=0x1234 and cfg word 3 = 0x1234; all other words remain 0.
- **Command pulse.** Write 0x0005 to 0x01000 with nWE held low for 20 clk. Expect proc_cmd=5 and proc_start high for exactly 1 cycle at E2.
- **Busy drop and err clear.**
  - With proc_status=0x1, write 0xBEEF to 0x00000. Expect word 0 unchanged and STAT read = 0x8001.
  - Then write 0x8000 to 0x01002 with proc_status=0x0. Expect STAT read = 0x0000.
- **Result, unmapped and odd reads.**
  - With rd_bus word 2 = 0xA5A5, read 0x00804. Expect 0xA5A5.
  - Read 0x00400. Expect 0x0000.
  - Write 0xFFFF to 0x00003. Expect no register change.
- **Display scan.** Use DIV=4, N_DIG=6 and seg_value=0xFEDCBA. Expect digit 0: SEG_COM=011111, SEG_DATA=11101110 (A). After 4 clk, expect SEG_COM=101111, SEG_DATA=00111110 (b). Expect wrap to digit 0 after 24 clk.
- **Reset mid-write.** Hold nWE low across an nRESET pulse. Expect no commit after release and all outputs at their reset values.

Source files
------------

// File: rtl/host_regbank.sv
// Host-bus register bank: config words, command/status registers, result readback
// and a multiplexed hex 7-segment display scanner.
module host_regbank #(
  parameter int N_WREG = 24,
  parameter int N_RREG = 8,
  parameter int N_DIG  = 6,
  parameter int DIV    = 25000
) (
  input  logic                  clk,
  input  logic                  nRESET,
  input  logic                  HOST_nCS,
  input  logic                  HOST_nWE,
  input  logic                  HOST_nOE,
  input  logic [20:0]           HOST_ADD,
  input  logic [15:0]           HDI,
  output logic [15:0]           HDO,
  input  logic [16*N_RREG-1:0]  rd_bus,
  input  logic [3:0]            proc_status,
  output logic [16*N_WREG-1:0]  cfg_bus,
  output logic [3:0]            proc_cmd,
  output logic                  proc_start,
  input  logic [4*N_DIG-1:0]    seg_value,
  output logic [N_DIG-1:0]      SEG_COM,
  output logic [7:0]            SEG_DATA
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [19:0] RES_BASE  = 20'h00800;
  localparam logic [19:0] CMD_ADDR  = 20'h01000;
  localparam logic [19:0] STAT_ADDR = 20'h01002;

  logic [2:0]       syncA_q, syncB_q;
  logic [1:0]       fill_q;
  logic             wrActDly_q, wrActDly_d;
  logic [15:0]      cfg_q [N_WREG];
  logic [15:0]      cfg_d [N_WREG];
  logic [3:0]       cmd_q, cmd_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [15:0]      hdo_q, hdo_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    digit_q, digit_d;
  logic [N_DIG-1:0] segCom_q, segCom_d;
  logic [7:0]       segData_q, segData_d;
  logic [3:0]       nibble;
  logic [6:0]       hexPat;

  logic        wrAct, rdAct, commit, isEven;
  logic [19:0] addr, resOff;
  logic        unusedBits;

  assign wrAct  = !syncB_q[2] && !syncB_q[1] && syncB_q[0];
  assign rdAct  = !syncB_q[2] && !syncB_q[0];
  assign commit = wrAct && !wrActDly_q;
  assign addr   = HOST_ADD[19:0];
  assign isEven = !addr[0];
  assign resOff = addr - RES_BASE;
  assign unusedBits = ^{HOST_ADD[20], resOff[0]};

  // The edge detector stays disarmed until the synchronisers have flushed their
  // reset value, so a strobe held across reset release never looks like a new access.
  assign wrActDly_d = fill_q[1] ? wrAct : 1'b1;

  always_comb begin
    cfg_d   = cfg_q;
    cmd_d   = cmd_q;
    start_d = 1'b0;
    err_d   = err_q;
    hdo_d   = hdo_q;
    if (commit && isEven) begin
      for (int k = 0; k < N_WREG; k++) begin
        if (addr[19:1] == 19'(k)) begin
          if (proc_status[0]) err_d = 1'b1;
          else cfg_d[k] = HDI;
        end
      end
      if (addr == CMD_ADDR) begin
        cmd_d   = HDI[3:0];
        start_d = 1'b1;
      end
      if (addr == STAT_ADDR && HDI[15]) err_d = 1'b0;
    end
    if (rdAct) begin
      hdo_d = '0;
      if (isEven) begin
        for (int k = 0; k < N_WREG; k++)
          if (addr[19:1] == 19'(k)) hdo_d = cfg_q[k];
        for (int k = 0; k < N_RREG; k++)
          if (addr >= RES_BASE && resOff[19:1] == 19'(k)) hdo_d = rd_bus[16*k +: 16];
        if (addr == CMD_ADDR)  hdo_d = {12'b0, cmd_q};
        if (addr == STAT_ADDR) hdo_d = {err_q, 11'b0, proc_status};
      end
    end
  end

  // Segment outputs are computed from the next digit index so they switch with it.
  always_comb begin
    presc_d  = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + 1'b1;
    digit_d  = digit_q;
    if (presc_q == PW'(DIV - 1))
      digit_d = (digit_q == DW'(N_DIG - 1)) ? '0 : digit_q + 1'b1;
    segCom_d = '1;
    nibble   = 4'h0;
    for (int i = 0; i < N_DIG; i++) begin
      if (digit_d == DW'(i)) begin
        segCom_d[N_DIG-1-i] = 1'b0;
        nibble = seg_value[4*i +: 4];
      end
    end
    hexPat = 7'b0000000;
    case (nibble)
      4'h0: hexPat = 7'b1111110;
      4'h1: hexPat = 7'b0110000;
      4'h2: hexPat = 7'b1101101;
      4'h3: hexPat = 7'b1111001;
      4'h4: hexPat = 7'b0110011;
      4'h5: hexPat = 7'b1011011;
      4'h6: hexPat = 7'b1011111;
      4'h7: hexPat = 7'b1110000;
      4'h8: hexPat = 7'b1111111;
      4'h9: hexPat = 7'b1111011;
      4'hA: hexPat = 7'b1110111;
      4'hB: hexPat = 7'b0011111;
      4'hC: hexPat = 7'b1001110;
      4'hD: hexPat = 7'b0111101;
      4'hE: hexPat = 7'b1001111;
      4'hF: hexPat = 7'b1000111;
      default: hexPat = 7'b0000000;
    endcase
    segData_d = {hexPat, 1'b0};
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      syncA_q    <= '1;
      syncB_q    <= '1;
      fill_q     <= '0;
      wrActDly_q <= 1'b1;
      for (int k = 0; k < N_WREG; k++) cfg_q[k] <= '0;
      cmd_q      <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      hdo_q      <= '0;
      presc_q    <= '0;
      digit_q    <= '0;
      segCom_q   <= '1;
      segData_q  <= '0;
    end else begin
      syncA_q    <= {HOST_nCS, HOST_nWE, HOST_nOE};
      syncB_q    <= syncA_q;
      fill_q     <= {fill_q[0], 1'b1};
      wrActDly_q <= wrActDly_d;
      cfg_q      <= cfg_d;
      cmd_q      <= cmd_d;
      start_q    <= start_d;
      err_q      <= err_d;
      hdo_q      <= hdo_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      segCom_q   <= segCom_d;
      segData_q  <= segData_d;
    end
  end

  for (genvar k = 0; k < N_WREG; k++) begin : g_cfgOut
    assign cfg_bus[16*k +: 16] = cfg_q[k];
  end

  assign HDO        = hdo_q;
  assign proc_cmd   = cmd_q;
  assign proc_start = start_q;
  assign SEG_COM    = segCom_q;
  assign SEG_DATA   = segData_q;

endmodule
